deskew_c: RTL and testbench
===========================

# deskew_c

Output de-skew buffer for the systolic matrix-multiply array. The array emits result column `j` of row `i` one cycle later per column, so each row leaves the array as a diagonal wavefront. `deskew_c` delays each column by the complementary amount so a whole result row appears on `Cout` in one cycle. It tags each row with a row index and flags the final row of a tile for the host-side result writer.

## Interface
- `BITS_C`, default 16: signed width of one result element.
- `DIM`, default 8: array dimension, which is the number of columns and the number of rows per tile. Must be ≥ 2.
- `clk`  input  1: the single clock; everything is rising-edge.
- `rst`  input  1: asynchronous, active-high reset.
- `clr`  input  1: synchronous clear of the valid pipeline and row counter.
- `en`  input  1: shift enable; when low, all state holds.
- `valid_in`  input  1: qualifies `Cin[0]` as column 0 of a new result row.
- `Cin`  input  signed [BITS_C-1:0] [DIM-1:0]: skewed column outputs of the array.
- `Cout`  output  signed [BITS_C-1:0] [DIM-1:0]: aligned result row.
- `valid_out`  output  1: `Cout` holds a complete row.
- `row_idx`  output  $clog2(DIM): index of the row on `Cout`, valid when `valid_out` is high.
- `done`  output  1: high while the last row of a tile (`row_idx == DIM-1`) is on `Cout`.

## Operation
- **Column delay lines.** Column `j` is a shift register of `DIM-j` stages of `BITS_C` bits.
  - Column 0 has `DIM` stages; column `DIM-1` has 1 stage.
  - All stages shift together on an enabled edge (`en=1`).
  - `Cout[j]` is the last stage of column `j`. Data passes through unmodified, with no arithmetic and no width change.
- **Valid pipeline.** `valid_in` passes through a `DIM`-stage 1-bit shift register driven by the same `en`. Its last stage is `valid_out`.
- **Alignment.**
  - Row `i`, column `j` presented at enabled edge `t0+i+j` reaches `Cout[j]` after edge `t0+i+DIM-1`.
  - Therefore all columns of row `i`, together with its `valid_out`, appear after the same edge.
- **Row counter.**
  - Counts rows leaving the block, and its value drives `row_idx`.
  - On an enabled edge where `valid_out` is currently 1, the counter increments.
  - It wraps from `DIM-1` to 0. When `DIM` is not a power of 2, wrap by compare, not by overflow.
- **`done`.** Combinational: `valid_out && row_idx == DIM-1`.
- **Priority:** `rst` > `clr` > `en`.
  - `clr=1` on an edge zeroes the valid pipeline and the row counter, regardless of `en`.
  - Data stages are not cleared by `clr`. They are don't-care while invalid.
- **Stall.** With `en=0` and `clr=0`, every register holds. `Cout`, `valid_out`, `row_idx` and `done` therefore stay constant. A `done` that was high stays high until the next enabled edge.
- **Gaps.** Rows need not be back-to-back. Bubbles (`valid_in=0`) propagate as `valid_out=0` and do not advance the counter.

## Timing
- **Reset state** (asynchronous, takes effect immediately on `rst=1`): all data stages 0, so `Cout` is all zeros. `valid_out=0`, `row_idx=0`, `done=0`.
- **Latency** counts enabled edges, not clock edges:
  - `Cin[j]` to `Cout[j]`: `DIM-j` enabled edges.
  - `valid_in` to `valid_out`: `DIM` enabled edges.
- **Throughput:** one row per enabled cycle.
- **Reset or clear mid-tile:** rows already in flight are dropped (`valid_out=0`) and the next valid row is numbered 0.
- **Simultaneous `clr` and `valid_in=1`:** that `valid_in` is discarded.
- All outputs are register-driven except `done`, which is one AND/compare level after registers.

## Test plan
All scenarios use `DIM=4`, `BITS_C=16`.
- **Reset values.** Assert `rst` asynchronously mid-cycle → immediately `Cout={0,0,0,0}`, `valid_out=0`, `row_idx=0`, `done=0`.
- **Full tile, back to back.** Drive a 4×4 tile skewed, with `C[i][j] = 16*i + j` and `valid_in` high on 4 consecutive cycles.
  - Expect `valid_out` high on 4 consecutive cycles, starting 4 enabled edges after the first `valid_in`.
  - Row `r` shows `Cout = {16r+3, 16r+2, 16r+1, 16r}` with `row_idx=r`.
  - `done` is high only with row 3.
- **Stall.** Same tile, with `en=0` for 3 cycles while row 1 is on the output → `Cout`, `valid_out=1` and `row_idx=1` held for 3 cycles, then the sequence resumes unchanged.
- **Bubbles.** One idle cycle between each row → `valid_out` alternates 1/0, `row_idx` goes 0,1,2,3, `done` is high once, and the counter wraps to 0 for the next tile.
- **Mid-tile clear.** Pulse `clr` after row 1 has been output, then send a new tile → no `valid_out` for in-flight rows 2–3; the new tile's first row has `row_idx=0`.
- **Negative values.** Inputs `-1`, `-32768`, `32767` on every column → output bit-exact, with no sign or width alteration.

Source files
------------

// File: rtl/deskew_c.sv
// Output de-skew buffer: delays each array column so a whole result row appears on Cout at once,
// tagging each row with its index within the tile and flagging the tile's final row.
module deskew_c #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             en,
  input  logic                             valid_in,
  input  logic signed [DIM-1:0][BITS_C-1:0] Cin,
  output logic signed [DIM-1:0][BITS_C-1:0] Cout,
  output logic                             valid_out,
  output logic [$clog2(DIM)-1:0]           row_idx,
  output logic                             done
);

  localparam int cw = $clog2(DIM);
  localparam logic [cw-1:0] last_row = cw'(DIM - 1);

  // Column j sees its element j cycles after column 0, so it needs j fewer stages.
  for (genvar j = 0; j < DIM; j++) begin : g_col
    localparam int stages = DIM - j;
    logic [BITS_C-1:0] sr_q [stages];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < stages; k++) sr_q[k] <= '0;
      end else if (en) begin
        sr_q[0] <= Cin[j];
        for (int k = 1; k < stages; k++) sr_q[k] <= sr_q[k-1];
      end
    end

    assign Cout[j] = sr_q[stages-1];
  end

  logic [DIM-1:0] vld_q;
  logic [cw-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (clr) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[DIM-2:0], valid_in};
    end
  end

  // Wrap by compare so non-power-of-two DIM still counts 0..DIM-1.
  always_comb begin
    cnt_d = cnt_q;
    if (vld_q[DIM-1]) begin
      cnt_d = (cnt_q == last_row) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign valid_out = vld_q[DIM-1];
  assign row_idx   = cnt_q;
  assign done      = valid_out && (cnt_q == last_row);

endmodule

// File: tb/tb_deskew_c.sv
// Directed bench for deskew_c with DIM=4, BITS_C=16: reset, full tile, stall, bubbles,
// mid-tile clear and signed extremes.
module tb_deskew_c;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clr;
  logic                     en;
  logic                     valid_in;
  logic signed [3:0][15:0]  Cin;
  logic signed [3:0][15:0]  Cout;
  logic                     valid_out;
  logic [1:0]               row_idx;
  logic                     done;

  int checks   = 0;
  int failures = 0;
  int m        = 0;  // expected row counter

  deskew_c #(.BITS_C(16), .DIM(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (en),
    .valid_in  (valid_in),
    .Cin       (Cin),
    .Cout      (Cout),
    .valid_out (valid_out),
    .row_idx   (row_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] val(input int base, input int i, input int j);
    int v;
    v = base + 16 * i + j;
    return v[15:0];
  endfunction

  task automatic check_out(input string tag, input logic exp_v, input int exp_row, input int base);
    logic [63:0] e;
    chk({tag, ".valid_out"}, 64'(valid_out), 64'(exp_v));
    chk({tag, ".row_idx"}, 64'(row_idx), 64'(m));
    chk({tag, ".done"}, 64'(done), 64'(exp_v && (m == 3)));
    if (exp_v) begin
      for (int j = 0; j < 4; j++) e[16*j +: 16] = val(base, exp_row, j);
      chk({tag, ".Cout"}, Cout, e);
    end
  endtask

  // Drives a skewed 4x4 tile with 'gap' idle cycles between rows. stall_c/clr_c select the
  // enabled cycle after which a 3-cycle stall happens / on whose edge clr is pulsed (-1: none).
  task automatic run_tile(input string tag, input int gap, input int stall_c, input int clr_c,
                          input int base);
    int   p;
    int   exp_row;
    logic exp_v;
    p = 1 + gap;
    for (int c = 0; c <= 3 * p + 4; c++) begin
      valid_in = (c % p == 0) && (c / p < 4);
      for (int j = 0; j < 4; j++) begin
        Cin[j] = 16'h5a5a ^ 16'(c);
        for (int i = 0; i < 4; i++) if (i * p + j == c) Cin[j] = val(base, i, j);
      end
      clr = (c == clr_c);
      @(posedge clk); #1;
      clr = 1'b0;
      if (c == clr_c) m = 0;
      exp_v   = 1'b0;
      exp_row = 0;
      for (int i = 0; i < 4; i++) begin
        if (i * p + 3 == c && (clr_c < 0 || i * p + 3 < clr_c || i * p > clr_c)) begin
          exp_v   = 1'b1;
          exp_row = i;
        end
      end
      check_out(tag, exp_v, exp_row, base);
      if (c == stall_c) begin
        en = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check_out({tag, ".stall"}, exp_v, exp_row, base);
        end
        en = 1'b1;
      end
      if (exp_v) m = (m + 1) % 4;
    end
    valid_in = 1'b0;
  endtask

  task automatic run_const(input logic [15:0] v);
    Cin      = {4{v}};
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("const.valid_out", 64'(valid_out), 64'(1));
    chk("const.row_idx", 64'(row_idx), 64'(m));
    chk("const.Cout", Cout, {4{v}});
    m = (m + 1) % 4;
    @(posedge clk); #1;
    chk("const.gap", 64'(valid_out), 64'(0));
  endtask

  initial begin
    rst      = 1'b1;
    clr      = 1'b0;
    en       = 1'b1;
    valid_in = 1'b0;
    Cin      = '0;
    #12;
    chk("reset.Cout", Cout, 64'(0));
    chk("reset.valid_out", 64'(valid_out), 64'(0));
    rst = 1'b0;

    // Fill the pipe with valid non-zero data, then reset asynchronously mid-cycle.
    Cin      = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    valid_in = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("prereset.valid_out", 64'(valid_out), 64'(1));
    chk("prereset.row_idx", 64'(row_idx), 64'(1));
    valid_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset.Cout", Cout, 64'(0));
    chk("async_reset.valid_out", 64'(valid_out), 64'(0));
    chk("async_reset.row_idx", 64'(row_idx), 64'(0));
    chk("async_reset.done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m   = 0;

    run_tile("full", 0, -1, -1, 0);
    run_tile("stall", 0, 4, -1, 256);
    run_tile("bubble", 1, -1, -1, 512);
    run_tile("clear", 0, -1, 5, 768);
    run_tile("after_clear", 0, -1, -1, 1024);

    run_const(16'hffff);
    run_const(16'h8000);
    run_const(16'h7fff);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
